// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch handshake, decode with registered immediate,
// EXEC/MEM/WB stepping, retire counting, and sticky traps for illegal opcodes and bus timeouts.
module multicycle_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  run_i,
    output logic                  imem_req_o,
    input  logic                  imem_valid_i,
    input  logic [31:0]           imem_rdata_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    input  logic                  dmem_done_i,
    input  logic                  branch_taken_i,
    output logic [31:0]           ir_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic                  alu_src_imm_o,
    output logic [1:0]            pc_sel_o,
    output logic                  pc_write_o,
    output logic                  rf_write_o,
    output logic                  retire_o,
    output logic [DATA_WIDTH-1:0] instret_o,
    output logic                  illegal_o,
    output logic                  bus_err_o
);

    // state  | meaning
    // IDLE   | parked, waiting for run
    // FETCH  | imem request outstanding
    // DECODE | immediate registered, opcode legality check
    // EXEC   | ALU step; branches resolve and retire here
    // MEM    | dmem request outstanding
    // WB     | register write, PC update, retire
    // TRAP   | halted until reset
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int          CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [31:0]             ir_q, ir_d;
    logic [DATA_WIDTH-1:0]   imm_q, imm_d;
    logic [DATA_WIDTH-1:0]   instret_q, instret_d;
    logic [CW-1:0]           wait_q, wait_d;
    logic                    illegal_q, illegal_d;
    logic                    bus_err_q, bus_err_d;

    logic [6:0]              opcode;
    logic                    is_r, is_branch, is_load, is_store, is_jal, is_jalr, supported;
    logic [31:0]             imm32;
    logic                    wait_hit;

    assign opcode    = ir_q[6:0];
    assign is_r      = (opcode == OP_R);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign supported = is_r || (opcode == OP_I) || is_load || is_store || is_branch || is_jal || is_jalr;

    // Last permitted wait cycle; a valid/done in this same cycle still completes normally.
    assign wait_hit  = (TIMEOUT != 0) && (wait_q == TO_LAST);

    always_comb begin
        imm32 = 32'd0;
        case (opcode)
            OP_I, OP_LOAD, OP_JALR: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            OP_STORE:               imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BRANCH:              imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            OP_JAL:                 imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:                imm32 = 32'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        imm_d         = imm_q;
        instret_d     = instret_q;
        wait_d        = wait_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        imem_req_o    = 1'b0;
        dmem_req_o    = 1'b0;
        dmem_we_o     = 1'b0;
        alu_src_imm_o = 1'b0;
        pc_sel_o      = 2'd0;
        pc_write_o    = 1'b0;
        rf_write_o    = 1'b0;
        retire_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (run_i) begin
                    state_d = FETCH;
                    wait_d  = '0;
                end
            end
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_valid_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = DECODE;
                end else if (wait_hit) begin
                    state_d   = TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            DECODE: begin
                imm_d = DATA_WIDTH'($signed(imm32));
                if (supported) begin
                    state_d = EXEC;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                alu_src_imm_o = !(is_r || is_branch);
                if (is_branch) begin
                    pc_write_o = 1'b1;
                    retire_o   = 1'b1;
                    pc_sel_o   = branch_taken_i ? 2'd1 : 2'd0;
                end else if (is_load || is_store) begin
                    state_d = MEM;
                    wait_d  = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_store;
                if (dmem_done_i) begin
                    if (is_store) begin
                        pc_write_o = 1'b1;
                        retire_o   = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_hit) begin
                    state_d   = TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            WB: begin
                rf_write_o = 1'b1;
                pc_write_o = 1'b1;
                retire_o   = 1'b1;
                pc_sel_o   = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every retiring path shares the counter bump and the run-gated return.
        if (retire_o) begin
            instret_d = instret_q + DATA_WIDTH'(1);
            state_d   = run_i ? FETCH : IDLE;
            wait_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            imm_q     <= '0;
            instret_q <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign ir_o      = ir_q;
    assign imm_o     = imm_q;
    assign instret_o = instret_q;
    assign illegal_o = illegal_q;
    assign bus_err_o = bus_err_q;

endmodule
